// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, ram size-select codes, FSM encoding and
//               request-decoding helpers for the load/store port.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] BS_BYTE = 2'd0;
    localparam logic [1:0] BS_HALF = 2'd1;
    localparam logic [1:0] BS_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Access width in bytes; only meaningful for legal width codes.
    function automatic logic [2:0] access_bytes(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] byte_sel_of(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   byte_sel_of = BS_BYTE;
            2'b01:   byte_sel_of = BS_HALF;
            default: byte_sel_of = BS_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Sign/zero extension of raw ram read data per RISC-V funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw_data,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = raw_data;
        case (funct3)
            F3_B:    ext_data = {{24{raw_data[7]}},  raw_data[7:0]};
            F3_H:    ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
            F3_BU:   ext_data = {24'd0, raw_data[7:0]};
            F3_HU:   ext_data = {16'd0, raw_data[15:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_port
// Description : Single-outstanding load/store port between a CPU request
//               channel and a byte-addressed ram with size select.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_port
    import lsu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_byte_sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] c_depth = 33'(DEPTH);

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_sel;

    logic        w_accept;
    logic        w_bad_f3;
    logic        w_misalign;
    logic        w_oob;
    logic        w_reject;
    logic [32:0] w_end;
    logic [31:0] w_ext;

    // ------------------------------------------------------------------
    // Request legality, evaluated on the live request inputs
    // ------------------------------------------------------------------
    assign w_bad_f3   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                     || (req_we && req_funct3[2]);
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign w_end      = {1'b0, req_addr} + {30'd0, access_bytes(req_funct3[1:0])};
    assign w_oob      = (w_end > c_depth);
    assign w_reject   = w_bad_f3 || w_misalign || w_oob;
    assign w_accept   = (r_state == IDLE) && req_valid;

    load_ext u_load_ext (
        .funct3   (r_funct3),
        .raw_data (mem_rdata),
        .ext_data (w_ext)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_reject ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                // Reset gates the write strobe without waiting for the edge
                mem_we = r_we && !rst;
                w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_sel   <= BS_BYTE;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_err    <= w_reject;
                r_rdata  <= 32'd0;
                // ram-side registers only move for requests that will access
                if (!w_reject) begin
                    r_mem_addr  <= req_addr;
                    r_mem_wdata <= req_wdata;
                    r_mem_sel   <= byte_sel_of(req_funct3[1:0]);
                end
            end
            if (r_state == ACCESS) begin
                r_rdata <= r_we ? 32'd0 : w_ext;
            end
        end
    end

    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_byte_sel = r_mem_sel;

endmodule
`default_nettype wire

// File: tb/tb_lsu_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_port
// Description : Directed scoreboard bench for lsu_port with a byte ram model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_byte_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors;
    int         miscompares;
    int         en_count;
    logic [7:0] ram [0:255];

    lsu_port #(.DEPTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_byte_sel (mem_byte_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte ram: combinational read, size-selected write
    always @* begin
        logic [7:0] a;
        a = mem_addr[7:0];
        mem_rdata = {ram[a + 8'd3], ram[a + 8'd2], ram[a + 8'd1], ram[a]};
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_byte_sel != 2'd0) ram[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_byte_sel == 2'd2) begin
                ram[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                ram[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count ram enables and score every completed response
    always @(negedge clk) begin
        if (mem_en) en_count++;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d with empty scoreboard",
                         rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // One request with rsp_ready held at 1, including latency checks
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        int en_before;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_q.push_back('{err: exp_err, rdata: exp_rdata});
        en_before  = en_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (!exp_err) begin
            chk("mem_en_N+1", {31'd0, mem_en}, 32'd1);
            chk("mem_addr_N+1", mem_addr, addr);
            @(negedge clk);
            chk("rsp_valid_N+2", {31'd0, rsp_valid}, 32'd1);
        end else begin
            chk("rsp_valid_rej", {31'd0, rsp_valid}, 32'd1);
        end
        @(negedge clk);
        chk("req_ready_N+3", {31'd0, req_ready}, 32'd1);
        if (exp_err) chk("no_mem_en_rej", en_count - en_before, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        en_count    = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_en",    {31'd0, mem_en},    32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_byte_sel",  {30'd0, mem_byte_sel}, 32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Main load/store path
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        issue(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        issue(1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
        issue(1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
        issue(1'b1, 3'b001, 32'h22, 32'h1234CAFE, 32'h0,        1'b0);
        issue(1'b0, 3'b010, 32'h20, 32'h0,        32'hCAFE0000, 1'b0);

        // Misalignment and range boundaries
        issue(1'b0, 3'b010, 32'h11,  32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b001, 32'h21,  32'hFFFF, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'hFC,  32'h0, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b000, 32'hFF,  32'hA5, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'hFF,  32'h0, 32'h000000A5, 1'b0);
        issue(1'b0, 3'b001, 32'hFF,  32'h0, 32'h0, 1'b1);
        issue(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);

        // Illegal width codes, then confirm the rejected store wrote nothing
        issue(1'b0, 3'b011, 32'h30, 32'h0,        32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h30, 32'h77777777, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h30, 32'h0,        32'h0, 1'b0);

        // Back-pressured response with a stray request during RESP
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0;
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hold_idle", {31'd0, req_ready}, 32'd1);
        chk("post_hold_mem_en", {31'd0, mem_en}, 32'd0);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);

        // Reset asserted mid-cycle during a store's ACCESS
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h20; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rstacc_mem_we_pre", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstacc_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rstacc_mem_en",    {31'd0, mem_en},    32'd0);
        chk("rstacc_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstacc_mem_addr",  mem_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b0, 3'b100, 32'h20, 32'h0, 32'h00000000, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
